// File: rtl/periph_comp.sv
// ---------------------------------------------------------------------------
// periph_comp -- Wishbone B3 classic slave comparator peripheral.
//
// Holds two 32-bit operands (OPA, OPB) and reports whether OPA is equal to,
// less than or greater than OPB, in unsigned or two's-complement mode. It also
// counts operand writes that leave both operands equal (MATCHCNT, saturating).
//
// Register map (index = adr[3:0]):
//    0x0 OPA       rw
//    0x1 RESULT    ro  {28'b0, SIGNED, GT, LT, EQ}
//    0x2 OPB       rw
//    0x3 CTRL      rw  [0] SIGNED, [1] CLR (write-1 clears MATCHCNT, reads 0)
//    0x4 MATCHCNT  ro
//    0x5..0xF      unmapped -> err
//
// Ports:
//    wb_periph_clk_i   bus clock, rising edge
//    wb_periph_rst_i   asynchronous active-low reset
//    wb_periph_adr_i   address, only [3:0] decoded
//    wb_periph_dat_i   write data
//    wb_periph_sel_i   byte enables
//    wb_periph_we_i    1 = write
//    wb_periph_cyc_i   cycle valid
//    wb_periph_stb_i   strobe
//    wb_periph_cti_i   ignored (classic only)
//    wb_periph_bte_i   ignored
//    wb_periph_dat_o   read data, non-zero only with a read ack
//    wb_periph_ack_o   normal termination, registered
//    wb_periph_err_o   error termination, registered
//    wb_periph_rty_o   always 0
// ---------------------------------------------------------------------------
module periph_comp (
   input  logic        wb_periph_clk_i,
   input  logic        wb_periph_rst_i,
   input  logic [31:0] wb_periph_adr_i,
   input  logic [31:0] wb_periph_dat_i,
   input  logic [3:0]  wb_periph_sel_i,
   input  logic        wb_periph_we_i,
   input  logic        wb_periph_cyc_i,
   input  logic        wb_periph_stb_i,
   input  logic [2:0]  wb_periph_cti_i,
   input  logic [1:0]  wb_periph_bte_i,
   output logic [31:0] wb_periph_dat_o,
   output logic        wb_periph_ack_o,
   output logic        wb_periph_err_o,
   output logic        wb_periph_rty_o
);

   localparam logic [3:0]  IDX_OPA      = 4'h0;
   localparam logic [3:0]  IDX_RESULT   = 4'h1;
   localparam logic [3:0]  IDX_OPB      = 4'h2;
   localparam logic [3:0]  IDX_CTRL     = 4'h3;
   localparam logic [3:0]  IDX_MATCHCNT = 4'h4;
   localparam logic [31:0] CNT_MAX      = 32'hFFFF_FFFF;

   // Byte-lane merge: lanes with their enable set take the new data.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
      logic [31:0] merged;
      merged = old_val;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) begin
            merged[8*b +: 8] = new_val[8*b +: 8];
         end else begin
            merged[8*b +: 8] = old_val[8*b +: 8];
         end
      end
      return merged;
   endfunction

   // State
   logic [31:0] opa_r;
   logic [31:0] opb_r;
   logic        signed_r;
   logic [31:0] matchcnt_r;
   logic        ack_r;
   logic        err_r;
   logic [31:0] dat_r;

   // Decode / datapath
   logic [3:0]  idx_s;
   logic        accept_s;
   logic        mapped_s;
   logic        writable_s;
   logic        bad_s;
   logic        wr_s;
   logic        rd_s;
   logic        eq_s;
   logic        lt_s;
   logic        gt_s;
   logic [31:0] result_s;
   logic [31:0] rd_data_s;
   logic [31:0] opa_nxt_s;
   logic [31:0] opb_nxt_s;
   logic        match_s;
   logic        unused_s;

   // Inputs that carry no meaning for a classic, locally decoded slave.
   assign unused_s = ^{wb_periph_cti_i, wb_periph_bte_i, wb_periph_adr_i[31:4]};

   // Access qualification and register index decode.
   always_comb begin
      idx_s      = wb_periph_adr_i[3:0];
      // A new access is only taken while no termination is being presented,
      // so a continuously held strobe yields one termination every two cycles.
      accept_s   = wb_periph_cyc_i & wb_periph_stb_i & ~ack_r & ~err_r;
      mapped_s   = 1'b0;
      writable_s = 1'b0;
      case (idx_s)
         IDX_OPA:      begin mapped_s = 1'b1; writable_s = 1'b1; end
         IDX_RESULT:   begin mapped_s = 1'b1; writable_s = 1'b0; end
         IDX_OPB:      begin mapped_s = 1'b1; writable_s = 1'b1; end
         IDX_CTRL:     begin mapped_s = 1'b1; writable_s = 1'b1; end
         IDX_MATCHCNT: begin mapped_s = 1'b1; writable_s = 1'b0; end
         default:      begin mapped_s = 1'b0; writable_s = 1'b0; end
      endcase
      bad_s = ~mapped_s | (wb_periph_we_i & ~writable_s);
      wr_s  = accept_s &  wb_periph_we_i & ~bad_s;
      rd_s  = accept_s & ~wb_periph_we_i & ~bad_s;
   end

   // Operand relation in the selected signedness.
   always_comb begin
      eq_s = (opa_r == opb_r);
      if (signed_r) begin
         lt_s = ($signed(opa_r) < $signed(opb_r));
         gt_s = ($signed(opa_r) > $signed(opb_r));
      end else begin
         lt_s = (opa_r < opb_r);
         gt_s = (opa_r > opb_r);
      end
      result_s = {28'd0, signed_r, gt_s, lt_s, eq_s};
   end

   // Read multiplexer, sampled from pre-edge register values.
   always_comb begin
      case (idx_s)
         IDX_OPA:      rd_data_s = opa_r;
         IDX_RESULT:   rd_data_s = result_s;
         IDX_OPB:      rd_data_s = opb_r;
         IDX_CTRL:     rd_data_s = {31'd0, signed_r};
         IDX_MATCHCNT: rd_data_s = matchcnt_r;
         default:      rd_data_s = 32'd0;
      endcase
   end

   // Post-write operand values and the equality check the match counter uses.
   always_comb begin
      opa_nxt_s = merge_bytes(opa_r, wb_periph_dat_i, wb_periph_sel_i);
      opb_nxt_s = merge_bytes(opb_r, wb_periph_dat_i, wb_periph_sel_i);
      // Always a full 32-bit compare, independent of SIGNED; a write with no
      // byte enables still counts if the operands are already equal.
      case (idx_s)
         IDX_OPA: match_s = (opa_nxt_s == opb_r);
         IDX_OPB: match_s = (opa_r == opb_nxt_s);
         default: match_s = 1'b0;
      endcase
   end

   // Operand and control registers.
   always_ff @(posedge wb_periph_clk_i or negedge wb_periph_rst_i) begin
      if (!wb_periph_rst_i) begin
         opa_r    <= 32'd0;
         opb_r    <= 32'd0;
         signed_r <= 1'b0;
      end else if (wr_s) begin
         case (idx_s)
            IDX_OPA:  opa_r <= opa_nxt_s;
            IDX_OPB:  opb_r <= opb_nxt_s;
            IDX_CTRL: begin
               if (wb_periph_sel_i[0]) begin
                  signed_r <= wb_periph_dat_i[0];
               end else begin
                  signed_r <= signed_r;
               end
            end
            default: begin
               opa_r    <= opa_r;
               opb_r    <= opb_r;
               signed_r <= signed_r;
            end
         endcase
      end else begin
         opa_r    <= opa_r;
         opb_r    <= opb_r;
         signed_r <= signed_r;
      end
   end

   // Saturating match counter with write-1 clear through CTRL[1].
   always_ff @(posedge wb_periph_clk_i or negedge wb_periph_rst_i) begin
      if (!wb_periph_rst_i) begin
         matchcnt_r <= 32'd0;
      end else if (wr_s && (idx_s == IDX_CTRL) && wb_periph_sel_i[0] && wb_periph_dat_i[1]) begin
         matchcnt_r <= 32'd0;
      end else if (wr_s && match_s && (matchcnt_r != CNT_MAX)) begin
         matchcnt_r <= matchcnt_r + 32'd1;
      end else begin
         matchcnt_r <= matchcnt_r;
      end
   end

   // Bus termination and read data; both terminations last one cycle.
   always_ff @(posedge wb_periph_clk_i or negedge wb_periph_rst_i) begin
      if (!wb_periph_rst_i) begin
         ack_r <= 1'b0;
         err_r <= 1'b0;
         dat_r <= 32'd0;
      end else begin
         ack_r <= accept_s & ~bad_s;
         err_r <= accept_s &  bad_s;
         if (rd_s) begin
            dat_r <= rd_data_s;
         end else begin
            dat_r <= 32'd0;
         end
      end
   end

   assign wb_periph_dat_o = dat_r;
   assign wb_periph_ack_o = ack_r;
   assign wb_periph_err_o = err_r;
   assign wb_periph_rty_o = 1'b0;

endmodule

// File: tb/tb_periph_comp.sv
// ---------------------------------------------------------------------------
// tb_periph_comp -- self-checking bench for periph_comp.
// A behavioural register model predicts ack/err/dat/rty for every cycle; a
// negedge process compares them. Directed reads are also pinned to literals.
// ---------------------------------------------------------------------------
module tb_periph_comp;

   logic        clk;
   logic        rst_n;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic [3:0]  sel;
   logic        we;
   logic        cyc;
   logic        stb;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic [31:0] dat_r;
   logic        ack;
   logic        err;
   logic        rty;

   periph_comp dut (
      .wb_periph_clk_i (clk),
      .wb_periph_rst_i (rst_n),
      .wb_periph_adr_i (adr),
      .wb_periph_dat_i (dat_w),
      .wb_periph_sel_i (sel),
      .wb_periph_we_i  (we),
      .wb_periph_cyc_i (cyc),
      .wb_periph_stb_i (stb),
      .wb_periph_cti_i (cti),
      .wb_periph_bte_i (bte),
      .wb_periph_dat_o (dat_r),
      .wb_periph_ack_o (ack),
      .wb_periph_err_o (err),
      .wb_periph_rty_o (rty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   // Model state
   logic [31:0] m_opa;
   logic [31:0] m_opb;
   logic        m_signed;
   logic [31:0] m_cnt;

   // Expected outputs for the current cycle
   logic        chk_en;
   logic        exp_ack;
   logic        exp_err;
   logic [31:0] exp_dat;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("ack", {31'd0, ack}, {31'd0, exp_ack});
         check("err", {31'd0, err}, {31'd0, exp_err});
         check("dat", dat_r, exp_dat);
         check("rty", {31'd0, rty}, 32'd0);
      end
   end

   function automatic logic [31:0] m_result();
      logic eq, lt, gt;
      int   sa, sb;
      sa = int'(m_opa);
      sb = int'(m_opb);
      eq = (m_opa == m_opb);
      lt = m_signed ? (sa < sb) : (m_opa < m_opb);
      gt = !eq && !lt;
      return {28'd0, m_signed, gt, lt, eq};
   endfunction

   function automatic logic [31:0] m_read(input logic [3:0] idx);
      case (idx)
         4'd0:    return m_opa;
         4'd1:    return m_result();
         4'd2:    return m_opb;
         4'd3:    return {31'd0, m_signed};
         4'd4:    return m_cnt;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] apply_bytes(input logic [31:0] old, input logic [31:0] d,
                                               input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // One accepted access: set expected termination and update the model.
   task automatic model_access(input logic w, input logic [3:0] idx, input logic [31:0] d,
                               input logic [3:0] s);
      logic is_err;
      is_err = (idx > 4'd4) || (w && (idx == 4'd1 || idx == 4'd4));
      exp_ack = !is_err;
      exp_err = is_err;
      exp_dat = (!is_err && !w) ? m_read(idx) : 32'd0;
      if (!is_err && w) begin
         if (idx == 4'd0) m_opa = apply_bytes(m_opa, d, s);
         if (idx == 4'd2) m_opb = apply_bytes(m_opb, d, s);
         if ((idx == 4'd0 || idx == 4'd2) && m_opa == m_opb && m_cnt != 32'hFFFF_FFFF)
            m_cnt = m_cnt + 32'd1;
         if (idx == 4'd3 && s[0]) begin
            m_signed = d[0];
            if (d[1]) m_cnt = 32'd0;
         end
      end
   endtask

   task automatic set_idle();
      exp_ack = 1'b0;
      exp_err = 1'b0;
      exp_dat = 32'd0;
   endtask

   // Drive one request, holding stb for 'hold' edges; rd returns dat_o at the
   // last termination.
   task automatic access(input logic w, input logic [3:0] idx, input logic [31:0] d,
                         input logic [3:0] s, input int hold, output logic [31:0] rd);
      logic [31:0] hi;
      hi    = $urandom();
      adr   = {hi[27:0], idx};
      we    = w;
      dat_w = d;
      sel   = s;
      cyc   = 1'b1;
      stb   = 1'b1;
      rd    = 32'd0;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         if (i % 2 == 0) begin
            model_access(w, idx, d, s);
            rd = dat_r;
         end else begin
            set_idle();
         end
      end
      cyc = 1'b0;
      stb = 1'b0;
      @(posedge clk);
      #1;
      set_idle();
   endtask

   task automatic model_reset();
      m_opa    = 32'd0;
      m_opb    = 32'd0;
      m_signed = 1'b0;
      m_cnt    = 32'd0;
      set_idle();
   endtask

   logic [31:0] rd;
   logic [31:0] d;
   logic [3:0]  idx;
   logic [3:0]  s;
   logic        w;

   initial begin
      chk_en = 1'b0;
      rst_n  = 1'b1;
      adr = 32'd0; dat_w = 32'd0; sel = 4'd0; we = 1'b0;
      cyc = 1'b0; stb = 1'b0; cti = 3'd0; bte = 2'd0;
      model_reset();
      #1 rst_n = 1'b0;
      chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset values
      access(1'b0, 4'd0, 32'd0, 4'hF, 1, rd); check("rst_opa", rd, 32'h0);
      access(1'b0, 4'd1, 32'd0, 4'hF, 1, rd); check("rst_result", rd, 32'h1);
      access(1'b0, 4'd2, 32'd0, 4'hF, 1, rd); check("rst_opb", rd, 32'h0);
      access(1'b0, 4'd3, 32'd0, 4'hF, 1, rd); check("rst_ctrl", rd, 32'h0);
      access(1'b0, 4'd4, 32'd0, 4'hF, 1, rd); check("rst_cnt", rd, 32'h0);

      // Directed sequence
      access(1'b1, 4'd0, 32'hDEADBEEF, 4'hF, 2, rd);
      access(1'b0, 4'd1, 32'd0, 4'hF, 1, rd); check("unsigned_gt", rd, 32'h4);
      access(1'b0, 4'd0, 32'd0, 4'hF, 1, rd); check("opa_rd", rd, 32'hDEADBEEF);
      access(1'b1, 4'd3, 32'h1, 4'hF, 1, rd);
      access(1'b0, 4'd1, 32'd0, 4'hF, 1, rd); check("signed_lt", rd, 32'hA);
      access(1'b1, 4'd2, 32'hDEADBEEF, 4'hF, 1, rd);
      access(1'b0, 4'd4, 32'd0, 4'hF, 1, rd); check("cnt_one", rd, 32'h1);
      access(1'b0, 4'd1, 32'd0, 4'hF, 1, rd); check("result_eq", rd, 32'h9);
      access(1'b1, 4'd3, 32'h3, 4'hF, 1, rd);
      access(1'b0, 4'd4, 32'd0, 4'hF, 1, rd); check("cnt_clr", rd, 32'h0);
      access(1'b0, 4'd3, 32'd0, 4'hF, 1, rd); check("ctrl_rd", rd, 32'h1);
      access(1'b1, 4'd0, 32'h12345678, 4'h3, 1, rd);
      access(1'b0, 4'd0, 32'd0, 4'hF, 1, rd); check("byte_wr", rd, 32'hDEAD5678);
      access(1'b1, 4'd2, 32'h0BADF00D, 4'h0, 1, rd);
      access(1'b0, 4'd2, 32'd0, 4'hF, 1, rd); check("sel0_wr", rd, 32'hDEADBEEF);
      access(1'b0, 4'd7, 32'd0, 4'hF, 1, rd); check("err_rd_dat", rd, 32'h0);
      access(1'b1, 4'd1, 32'hFFFFFFFF, 4'hF, 1, rd);
      access(1'b1, 4'd4, 32'hFFFFFFFF, 4'hF, 1, rd);
      access(1'b0, 4'd0, 32'd0, 4'hF, 1, rd); check("err_nochg", rd, 32'hDEAD5678);
      access(1'b0, 4'd0, 32'd0, 4'hF, 5, rd);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         idx = 4'($urandom_range(0, 9));
         if (idx > 4'd4) idx = 4'($urandom_range(5, 15));
         w = 1'($urandom_range(0, 1));
         d = $urandom();
         s = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) begin
            d = (idx == 4'd0) ? m_opb : m_opa;
            s = 4'hF;
         end
         if (idx == 4'd3 && $urandom_range(0, 7) != 0) d[1] = 1'b0;
         access(w, idx, d, s, int'($urandom_range(1, 3)), rd);
      end

      // Reset while a termination is pending
      adr = 32'd0; we = 1'b0; cyc = 1'b1; stb = 1'b1;
      @(posedge clk);
      #2;
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check("rst_ack", {31'd0, ack}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_dat", dat_r, 32'd0);
      model_reset();
      cyc = 1'b0; stb = 1'b0;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      access(1'b0, 4'd0, 32'd0, 4'hF, 1, rd); check("post_rst_opa", rd, 32'h0);
      access(1'b0, 4'd1, 32'd0, 4'hF, 1, rd); check("post_rst_res", rd, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
